// File: rtl/xterm_tty_pkg.sv
// Shared types and helpers for the xterm_tty UART console endpoint.
package xterm_tty_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

  localparam int unsigned FRAME_BITS = 10;
  localparam int unsigned DATA_BITS  = 8;

  // Clocks per bit, rounded to nearest.
  function automatic int unsigned baud_div(input int unsigned clk_hz, input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/xterm_tty_tx.sv
// 8N1 UART transmitter: start bit, 8 data bits LSB first, stop bit.
module xterm_tty_tx
  import xterm_tty_pkg::*;
#(
  parameter int unsigned DIV = 434
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] data_i,
  input  logic       start_i,
  output logic       txd_o,
  output logic       busy_o
);

  localparam int unsigned CW = $clog2(DIV + 1);

  uart_state_t          state_q;
  logic [CW-1:0]        cnt_q;
  logic [2:0]           bit_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 txd_q;
  logic                 busy_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            shift_q <= data_i;
            txd_q   <= 1'b0;
            busy_q  <= 1'b1;
            cnt_q   <= CW'(DIV);
            state_q <= START;
          end
        end
        START: begin
          if (cnt_q == CW'(1)) begin
            txd_q   <= shift_q[0];
            shift_q <= {1'b0, shift_q[DATA_BITS-1:1]};
            bit_q   <= '0;
            cnt_q   <= CW'(DIV);
            state_q <= DATA;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        DATA: begin
          if (cnt_q == CW'(1)) begin
            cnt_q <= CW'(DIV);
            if (bit_q == 3'(DATA_BITS - 1)) begin
              txd_q   <= 1'b1;
              state_q <= STOP;
            end else begin
              txd_q   <= shift_q[0];
              shift_q <= {1'b0, shift_q[DATA_BITS-1:1]};
              bit_q   <= bit_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        STOP: begin
          if (cnt_q == CW'(1)) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign txd_o  = txd_q;
  assign busy_o = busy_q;

endmodule

// File: rtl/xterm_tty.sv
// UART console endpoint: receives SoC bytes (and echoes them to the simulator
// console) and serialises host bytes back towards the SoC.
module xterm_tty
  import xterm_tty_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned BAUD    = 115_200,
  parameter bit          CONSOLE = 1'b1
) (
  input  logic       CLOCK_50,
  input  logic       KEY0,
  input  logic       TX_in,
  output logic       RX_out,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy
);

  localparam int unsigned DIV  = baud_div(CLK_HZ, BAUD);
  localparam int unsigned HALF = DIV / 2;
  localparam int unsigned CW   = $clog2(DIV + 1);

  logic                 sync1_q;
  logic                 sync2_q;
  uart_state_t          rx_state_q;
  logic [CW-1:0]        rx_cnt_q;
  logic [2:0]           rx_bit_q;
  logic [DATA_BITS-1:0] rx_shift_q;
  logic [7:0]           rx_data_q;
  logic                 rx_valid_q;
  logic                 rx_err_q;

  // Start is confirmed mid-bit; a line high again at that point is a glitch.
  always_ff @(posedge CLOCK_50) begin
    if (!KEY0) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      rx_state_q <= IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
    end else begin
      sync1_q    <= TX_in;
      sync2_q    <= sync1_q;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
      case (rx_state_q)
        IDLE: begin
          if (!sync2_q) begin
            rx_cnt_q   <= CW'(HALF);
            rx_state_q <= START;
          end
        end
        START: begin
          if (rx_cnt_q == CW'(1)) begin
            if (!sync2_q) begin
              rx_cnt_q   <= CW'(DIV);
              rx_bit_q   <= '0;
              rx_state_q <= DATA;
            end else begin
              rx_state_q <= IDLE;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q - CW'(1);
          end
        end
        DATA: begin
          if (rx_cnt_q == CW'(1)) begin
            rx_shift_q <= {sync2_q, rx_shift_q[DATA_BITS-1:1]};
            rx_cnt_q   <= CW'(DIV);
            if (rx_bit_q == 3'(DATA_BITS - 1)) begin
              rx_state_q <= STOP;
            end else begin
              rx_bit_q <= rx_bit_q + 3'd1;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q - CW'(1);
          end
        end
        STOP: begin
          if (rx_cnt_q == CW'(1)) begin
            if (sync2_q) begin
              rx_data_q  <= rx_shift_q;
              rx_valid_q <= 1'b1;
            end else begin
              rx_err_q <= 1'b1;
            end
            rx_state_q <= IDLE;
          end else begin
            rx_cnt_q <= rx_cnt_q - CW'(1);
          end
        end
        default: rx_state_q <= IDLE;
      endcase
    end
  end

  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign rx_frame_err = rx_err_q;

  xterm_tty_tx #(
    .DIV(DIV)
  ) u_tx (
    .clk_i  (CLOCK_50),
    .rst_ni (KEY0),
    .data_i (tx_data),
    .start_i(tx_start),
    .txd_o  (RX_out),
    .busy_o (tx_busy)
  );

`ifndef SYNTHESIS
  always_ff @(posedge CLOCK_50) begin
    if (CONSOLE && rx_valid_q && rx_data_q != 8'h0D) begin
      $write("%c", rx_data_q);
    end
  end
`endif

endmodule

// File: tb/tb_xterm_tty.sv
// Self-checking bench for xterm_tty: directed and randomized RX/TX traffic
// checked against an event-level model of the serial protocol.
module tb_xterm_tty;

  localparam int DIV        = 434;
  localparam int HALF       = DIV / 2;
  localparam int RX_LAT     = 2 + HALF + 9 * DIV;
  localparam int FRAME_CLKS = 10 * DIV;

  typedef struct {
    int         cyc;
    logic [1:0] kind;
    logic [7:0] data;
  } ev_t;

  logic       CLOCK_50 = 1'b0;
  logic       KEY0;
  logic       TX_in;
  logic       RX_out;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;

  int         cycle = 0;
  int         totalChecks = 0;
  int         badChecks = 0;
  logic [7:0] lastData = 8'h00;
  ev_t        expQ[$];
  ev_t        obsQ[$];

  xterm_tty #(
    .CLK_HZ (50_000_000),
    .BAUD   (115_200),
    .CONSOLE(1'b0)
  ) dut (
    .CLOCK_50    (CLOCK_50),
    .KEY0        (KEY0),
    .TX_in       (TX_in),
    .RX_out      (RX_out),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_frame_err(rx_frame_err),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .tx_busy     (tx_busy)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) cycle <= cycle + 1;

  // Every cycle carrying a receive strobe becomes one observed event.
  always @(negedge CLOCK_50) begin
    if (rx_valid || rx_frame_err) begin
      obsQ.push_back('{cyc: cycle, kind: {rx_frame_err, rx_valid}, data: rx_data});
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    totalChecks++;
    if (got !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void modelFrame(input int startCyc, input logic [7:0] b, input logic stopBit);
    ev_t e;
    e.cyc = startCyc + 1 + RX_LAT;
    if (stopBit) begin
      e.kind   = 2'b01;
      lastData = b;
    end else begin
      e.kind = 2'b10;
    end
    e.data = lastData;
    expQ.push_back(e);
  endfunction

  task automatic idleLine(input int n);
    TX_in = 1'b1;
    repeat (n) begin
      @(posedge CLOCK_50);
      #1;
    end
  endtask

  // Drives one frame on TX_in; caller is aligned just after a clock edge.
  task automatic applyStimulus(input logic [7:0] b, input logic stopBit);
    logic [9:0] bits;
    bits = {stopBit, b, 1'b0};
    modelFrame(cycle, b, stopBit);
    for (int i = 0; i < 10; i++) begin
      TX_in = bits[i];
      repeat (DIV) begin
        @(posedge CLOCK_50);
        #1;
      end
    end
    TX_in = 1'b1;
  endtask

  task automatic txFrame(input logic [7:0] b, input int ignoreAt);
    logic [9:0] bits;
    bits     = {1'b1, b, 1'b0};
    tx_data  = b;
    tx_start = 1'b1;
    @(posedge CLOCK_50);
    #1;
    tx_start = 1'b0;
    for (int k = 0; k < FRAME_CLKS; k++) begin
      if (k == ignoreAt) begin
        tx_data  = ~b;
        tx_start = 1'b1;
      end else if (k == ignoreAt + 1) begin
        tx_data  = b;
        tx_start = 1'b0;
      end
      if (k % DIV == 0 || k % DIV == DIV - 1) begin
        checkOutput("txLine", RX_out, bits[k / DIV]);
        checkOutput("txBusy", tx_busy, 1);
      end
      @(posedge CLOCK_50);
      #1;
    end
    checkOutput("txLineEnd", RX_out, 1);
    checkOutput("txBusyEnd", tx_busy, 0);
  endtask

  initial begin
    int nCmp;
    logic prevErr;
    KEY0     = 1'b0;
    TX_in    = 1'b1;
    tx_start = 1'b0;
    tx_data  = 8'h00;
    repeat (4) @(posedge CLOCK_50);
    #1;
    checkOutput("rstLine", RX_out, 1);
    checkOutput("rstValid", rx_valid, 0);
    checkOutput("rstErr", rx_frame_err, 0);
    checkOutput("rstBusy", tx_busy, 0);
    checkOutput("rstData", rx_data, 8'h00);
    KEY0 = 1'b1;
    idleLine(10);

    applyStimulus(8'h41, 1'b1);
    idleLine(DIV);
    checkOutput("rxDataA", rx_data, 8'h41);

    applyStimulus(8'h7E, 1'b0);
    idleLine(2 * DIV);
    checkOutput("rxDataHeld", rx_data, 8'h41);

    TX_in = 1'b0;
    repeat (50) begin
      @(posedge CLOCK_50);
      #1;
    end
    idleLine(DIV);

    applyStimulus(8'h48, 1'b1);
    applyStimulus(8'h69, 1'b1);
    idleLine(DIV);
    checkOutput("rxDataHi", rx_data, 8'h69);

    txFrame(8'h55, 1234);

    // Reset lands 2000 clocks into both a TX frame and an RX frame.
    tx_data  = 8'hA5;
    tx_start = 1'b1;
    TX_in    = 1'b0;
    @(posedge CLOCK_50);
    #1;
    tx_start = 1'b0;
    repeat (1999) begin
      @(posedge CLOCK_50);
      #1;
    end
    KEY0 = 1'b0;
    @(posedge CLOCK_50);
    #1;
    checkOutput("abortLine", RX_out, 1);
    checkOutput("abortBusy", tx_busy, 0);
    checkOutput("abortValid", rx_valid, 0);
    KEY0     = 1'b1;
    TX_in    = 1'b1;
    lastData = 8'h00;
    checkOutput("abortData", rx_data, 8'h00);
    idleLine(3000);

    fork
      begin
        prevErr = 1'b0;
        for (int n = 0; n < 6; n++) begin
          logic [7:0] b;
          logic       stopBit;
          b       = 8'($urandom);
          stopBit = ($urandom_range(0, 3) != 0);
          if (prevErr || $urandom_range(0, 2) == 0) begin
            idleLine($urandom_range(DIV, 2 * DIV));
            if ($urandom_range(0, 1) == 1) begin
              TX_in = 1'b0;
              repeat ($urandom_range(1, HALF - 1)) begin
                @(posedge CLOCK_50);
                #1;
              end
              idleLine(DIV);
            end
          end
          applyStimulus(b, stopBit);
          prevErr = ~stopBit;
        end
        idleLine(2 * DIV);
      end
      begin
        for (int n = 0; n < 5; n++) begin
          txFrame(8'($urandom), ($urandom_range(0, 1) == 1) ? int'($urandom_range(10, 4000)) : -1);
          repeat ($urandom_range(0, 50)) begin
            @(posedge CLOCK_50);
            #1;
          end
        end
      end
    join

    idleLine(DIV);
    checkOutput("evCount", obsQ.size(), expQ.size());
    nCmp = (obsQ.size() < expQ.size()) ? obsQ.size() : expQ.size();
    for (int i = 0; i < nCmp; i++) begin
      checkOutput("evCycle", obsQ[i].cyc, expQ[i].cyc);
      checkOutput("evKind", obsQ[i].kind, expQ[i].kind);
      checkOutput("evData", obsQ[i].data, expQ[i].data);
    end

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule

// File: doc/xterm_tty.md
# xterm_tty

UART console endpoint for the DE2 simulation and board environment, attached to the board UART pins. Receives 8N1 serial frames on `TX_in` (the SoC's UART_TXD), presents each byte as a one-cycle strobe, and prints it to the simulator console. Also serialises host bytes onto `RX_out` (the SoC's UART_RXD), which otherwise idles high.

## Interface
- `CLK_HZ`, 50_000_000: clock frequency.
- `BAUD`, 115_200: line rate.
- Derived `DIV` = round(CLK_HZ/BAUD) = 434 clocks per bit; `HALF` = DIV/2 = 217.

Ports:
- `CLOCK_50`  in  1  system clock; all logic on rising edge.
- `KEY0`  in  1  reset; synchronous, active-low (DE2 pushbutton polarity).
- `TX_in`  in  1  serial line from the SoC; asynchronous, idles high.
- `RX_out`  out  1  serial line to the SoC; idles high.
- `rx_data`  out  8  last received byte.
- `rx_valid`  out  1  one-cycle strobe; `rx_data` is valid in that cycle.
- `rx_frame_err`  out  1  one-cycle strobe when a frame is received with stop bit = 0.
- `tx_data`  in  8  byte to send.
- `tx_start`  in  1  send request; sampled only when `tx_busy`=0.
- `tx_busy`  out  1  high while a frame is being sent.

## Operation
- **Reset** (`KEY0`=0 at a clock edge): `RX_out`=1, `rx_valid`=0, `rx_frame_err`=0, `tx_busy`=0, `rx_data`=8'h00. Both FSMs go to IDLE and all counters clear. Reset mid-frame aborts the frame immediately.
- **Receive path:**
  - `TX_in` passes through a 2-flop synchroniser; the receiver uses only the synchronised value.
  - FSM states IDLE → START → DATA → STOP → IDLE.
  - IDLE: a synchronised 0 moves the FSM to START and loads the counter with HALF.
  - START: at count expiry, sample the line. 0 → go to DATA with counter = DIV. 1 → treat as a glitch and return to IDLE with no output.
  - DATA: sample every DIV clocks, 8 bits, LSB first, into a shift register, then go to STOP.
  - STOP: sample after DIV clocks.
    - Sample = 1: `rx_data` ← byte and `rx_valid`=1 for one cycle.
    - Sample = 0: `rx_frame_err`=1 for one cycle, `rx_data` unchanged.
    - Either way, return to IDLE. A new start bit is accepted in the next cycle, so back-to-back frames are received.
- **Console:** simulation-only block, excluded from synthesis. On each `rx_valid`, `$write` the byte as a character; 8'h0D is suppressed.
- **Transmit path:**
  - FSM states IDLE → START → DATA → STOP → IDLE, each bit held for DIV clocks.
  - `tx_start`=1 in IDLE latches `tx_data`.
  - `RX_out` sequence: 0 (start), data LSB first, 1 (stop).
  - `tx_start` while busy is ignored.

## Timing
- `rx_valid` asserts exactly 2 + HALF + 9·DIV = 4125 clocks after the first rising edge at which `TX_in` is sampled low.
- TX: `tx_busy` and `RX_out`=0 take effect on the edge after `tx_start` is accepted. The frame lasts 10·DIV = 4340 clocks. `tx_busy` falls at the end of the stop bit, and a new `tx_start` can be accepted in that same cycle.
- Glitch rule: any low pulse shorter than HALF clocks produces no output.
- Both paths run simultaneously and independently.

## Structure
- Package `xterm_tty_pkg`:
  - `uart_state_t` enum (IDLE, START, DATA, STOP).
  - Function `baud_div(clk_hz, baud)` (rounded).
  - Constants for frame length (10 bits) and data width (8).
- Sub-module `xterm_tty_tx` holds the transmitter FSM. Receiver, synchroniser and console logic stay in the top.

## Test plan
- Drive 0x41 on `TX_in` at 115200 baud → `rx_data`=0x41 with `rx_valid` for exactly 1 cycle, 4125 clocks after the start edge; console shows "A".
- Frame 0x7E with stop bit forced to 0 → `rx_frame_err` 1-cycle pulse, no `rx_valid`, `rx_data` keeps its previous value.
- 1 µs low glitch (50 clocks) on an idle line → no `rx_valid`, no error, FSM back in IDLE.
- Bytes 0x48, 0x69 back-to-back with no idle gap → two `rx_valid` strobes 4340 clocks apart; console shows "Hi".
- `tx_start` with `tx_data`=0x55 → `RX_out` = 0,1,0,1,0,1,0,1,0,1, each held 434 clocks; `tx_busy` high for 4340 clocks; a second `tx_start` mid-frame is ignored.
- `KEY0`=0 at clock 2000 of a TX frame and mid-RX frame → next edge `RX_out`=1 and `tx_busy`=0; no `rx_valid` is emitted for the aborted frame.
